encrypt_scheduler: RTL and testbench

- Shares the single 64-bit Encrypter pipeline between N_REQ ballot-record producers in the EVM.
- Each cycle it picks one requester round-robin and latches that requester's plaintext together with the system key.
- It then drives the Encrypter's set/status handshake and returns the ciphertext tagged with the requester ID.
- A watchdog aborts an operation if status never rises.

---
 rtl/evm_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/encrypt_scheduler.sv | 155 +++++++++++++++
 tb/tb_encrypt_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared EVM types and constants: scheduler FSM states, datapath width and ID sizing helper.
package evm_pkg;

  localparam int unsigned DATA_W = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp,
    StClear
  } state_e;

  // Width of a requester ID; a single requester still gets a 1-bit ID.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = evm_pkg::id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % N_REQ);
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encrypt_scheduler.sv
// Shares one Encrypter between N_REQ producers: round-robin grant, set/status handshake with a
// watchdog, and an ID-tagged response held under consumer backpressure.
module encrypt_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = evm_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CLR_CYC = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*DATA_W-1:0]           req_data,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [DATA_W-1:0]                 key_in,
  output logic                              enc_set,
  output logic [DATA_W-1:0]                 enc_data_in,
  output logic [DATA_W-1:0]                 enc_key_in,
  input  logic                              enc_status,
  input  logic [DATA_W-1:0]                 enc_data_out,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_W-1:0]                 rsp_data,
  output logic [evm_pkg::id_w(N_REQ)-1:0]   rsp_id,
  output logic                              rsp_error,
  output logic                              busy
);

  import evm_pkg::*;

  localparam int unsigned ID_W  = id_w(N_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  // The watchdog timer doubles as the CLEAR dwell counter, so CLR_CYC must not exceed TIMEOUT.
  localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'((CLR_CYC > 0) ? CLR_CYC - 1 : 0);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_error_q, rsp_error_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    key_d       = key_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    timer_d     = timer_q;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst so the accept pulse never escapes while the block is held in reset.
        if (grant_valid && !rst) begin
          req_ready = grant;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) data_d = req_data[i*DATA_W +: DATA_W];
          end
          key_d    = key_in;
          id_d     = grant_idx;
          rr_ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Status is checked first so a completion on the expiry cycle is not reported as a timeout.
        if (enc_status) begin
          rsp_data_d  = enc_data_out;
          rsp_error_d = 1'b0;
          state_d     = StResp;
        end else begin
          timer_d = timer_inc;
          if (timer_q == TMR_LAST) begin
            rsp_data_d  = '0;
            rsp_error_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          timer_d = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (timer_q >= CLR_LAST && !enc_status) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      key_q       <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      key_q       <= key_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      timer_q     <= timer_d;
    end
  end

  assign enc_set     = (state_q == StLaunch) || (state_q == StWait);
  assign enc_data_in = data_q;
  assign enc_key_in  = key_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = id_q;
  assign rsp_error   = rsp_error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_encrypt_scheduler.sv
// Randomised scoreboard bench for encrypt_scheduler with a behavioural Encrypter and requesters.
module tb_encrypt_scheduler;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int TMO = 255;
  localparam int CLR = 2;
  localparam logic [W-1:0] FIXED = 64'hDEADBEEFCAFEF00D;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   key_in = '0;
  logic           enc_set;
  logic [W-1:0]   enc_data_in, enc_key_in;
  logic           enc_status = 1'b0;
  logic [W-1:0]   enc_data_out = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_error;
  logic           busy;

  always #5 clk = ~clk;

  encrypt_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .key_in(key_in), .enc_set(enc_set), .enc_data_in(enc_data_in), .enc_key_in(enc_key_in),
    .enc_status(enc_status), .enc_data_out(enc_data_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_error(rsp_error),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in cipher of the Encrypter model; the scheduler treats it as opaque.
  function automatic logic [W-1:0] enc_f(input logic [W-1:0] d, input logic [W-1:0] k);
    return {d[27:0], d[63:28]} ^ k ^ 64'h9E3779B97F4A7C15;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Test controls
  int   lat = 5, sticky = 0, rdy_prob = 100, req_prob = 0;
  bit   lat_rand = 0, sticky_rand = 0, hang = 0, fixed_out = 0, bp_mode = 0, key_fixed = 0;
  bit   cont = 0;
  logic [N-1:0] req_en = '0;

  // Encrypter model: status rises `lat` cycles after set, lingers `sticky` cycles after set falls.
  int hi_cnt = 0, low_cnt = 0, cur_lat = 5, cur_sticky = 0;
  bit set_snap = 0, st = 0;
  always @(negedge clk) begin
    set_snap = enc_set;
    hi_cnt   = enc_set ? hi_cnt + 1 : 0;
  end
  always @(posedge clk) begin
    #1;
    if (set_snap) begin
      if (hi_cnt == 1) cur_lat = lat_rand ? int'($urandom_range(8, 1)) : lat;
      cur_sticky = sticky_rand ? int'($urandom_range(3, 0)) : sticky;
      low_cnt    = 0;
      if (!hang && hi_cnt >= cur_lat) st = 1'b1;
    end else if (st) begin
      if (low_cnt >= cur_sticky) st = 1'b0;
      else low_cnt++;
    end
    enc_status   = st;
    enc_data_out = st ? (fixed_out ? FIXED : enc_f(enc_data_in, enc_key_in)) : {$urandom, $urandom};
  end

  // Requesters: hold valid until accepted, then present fresh data.
  logic [N-1:0] acc = '0;
  always @(negedge clk) acc = rst ? '0 : (req_valid & req_ready);
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        req_valid[i]         = cont && req_en[i];
        req_data[i*W +: W]   = {$urandom, $urandom};
      end else if (!req_valid[i] && req_en[i] && int'($urandom_range(99, 0)) < req_prob) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = {$urandom, $urandom};
      end
    end
    if (!key_fixed) key_in = {$urandom, $urandom};
  end

  // Consumer
  int rv_cnt = 0, stall_cnt = 0;
  always @(negedge clk) begin
    rv_cnt = rsp_valid ? rv_cnt + 1 : 0;
    if (rsp_valid && !rsp_ready) stall_cnt++;
  end
  always @(posedge clk) begin
    #1;
    rsp_ready = bp_mode ? (rv_cnt >= 20) : (int'($urandom_range(99, 0)) < rdy_prob);
  end

  // Scoreboard and monitor
  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;
  rsp_t exp_q[$];
  int   grant_log[$];

  bit   free = 1, in_clear = 0, prev_hs = 0, prev_hold = 0;
  int   m_ptr = 0, clr_cnt = 0, set_run = 0;
  logic [1:0]   h_id;
  logic [W-1:0] h_data;
  logic         h_err;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ptr = 0; free = 1; in_clear = 0; prev_hs = 0; prev_hold = 0; set_run = 0;
    end else begin
      logic [N-1:0] oh;
      int g;
      oh = '0;
      g  = -1;
      chk("busy", 64'(busy), 64'(!free));
      if (free && req_valid != '0) begin
        g     = rr_pick(req_valid, m_ptr);
        oh[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(oh));
      if (g >= 0) begin
        rsp_t e;
        e.id   = 2'(g);
        e.err  = hang;
        e.data = hang ? '0 : (fixed_out ? FIXED : enc_f(req_data[g*W +: W], key_in));
        exp_q.push_back(e);
        grant_log.push_back(g);
        m_ptr = (g + 1) % N;
        free  = 0;
      end

      if (enc_set) set_run++;
      else if (set_run > 0) begin
        chk("set_len", 64'(set_run), 64'(hang ? TMO + 1 : cur_lat + 1));
        set_run = 0;
      end

      if (in_clear) begin
        clr_cnt++;
        if (clr_cnt >= CLR && !enc_status) begin
          in_clear = 0;
          free     = 1;
        end
      end

      if (prev_hs) chk("rsp_drop", 64'(rsp_valid), 64'd0);
      if (rsp_valid) begin
        chk("set_in_rsp", 64'(enc_set), 64'd0);
        if (prev_hold) begin
          chk("hold_id", 64'(rsp_id), 64'(h_id));
          chk("hold_data", rsp_data, h_data);
          chk("hold_err", 64'(rsp_error), 64'(h_err));
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id %0d data 0x%0h, required no response",
                     rsp_id, rsp_data);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_error", 64'(rsp_error), 64'(e.err));
          end
          in_clear = 1;
          clr_cnt  = 0;
        end
        h_id = rsp_id; h_data = rsp_data; h_err = rsp_error;
        prev_hold = !rsp_ready;
      end else begin
        prev_hold = 0;
      end
      prev_hs = rsp_valid && rsp_ready;
    end
  end

  task automatic single_req(input int i, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    req_valid[i]       = 1'b1;
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_quiet(input int budget);
    int c;
    c = 0;
    while (!(free && exp_q.size() == 0 && req_valid == '0)) begin
      @(negedge clk);
      #1;
      c++;
      if (c > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_quiet: still busy after %0d cycles, required idle", c);
        return;
      end
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c;
    c = 0;
    while (grant_log.size() < n) begin
      @(negedge clk);
      #1;
      c++;
      if (c > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_grants: %0d grants, required %0d", grant_log.size(), n);
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_enc_set"}, 64'(enc_set), 64'd0);
    chk({tag, "_enc_data_in"}, enc_data_in, 64'd0);
    chk({tag, "_enc_key_in"}, enc_key_in, 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int c, rv_seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request with fixed vectors
    key_fixed = 1; key_in = 64'h133457799BBCDFF1; fixed_out = 1; lat = 5;
    single_req(2, 64'h0123456789ABCDEF);
    wait_quiet(100);
    fixed_out = 0; key_fixed = 0;

    // Round-robin fairness from reset with all requesters always valid
    req_en = '0;
    do_reset();
    grant_log.delete();
    lat = 3; cont = 1; req_prob = 100; req_en = '1;
    wait_grants(6, 300);
    cont = 0; req_en = '0; req_prob = 0;
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("rr_order", 64'(grant_log[k]), 64'(k % N));
    wait_quiet(300);

    // Backpressure: two queued requests, each response stalled 20 cycles
    bp_mode = 1; stall_cnt = 0;
    single_req(1, {$urandom, $urandom});
    repeat (2) @(posedge clk);
    single_req(3, {$urandom, $urandom});
    wait_quiet(200);
    chk("bp_stall", 64'(stall_cnt), 64'd40);
    bp_mode = 0;

    // Watchdog timeout, then a normal operation
    hang = 1;
    single_req(3, {$urandom, $urandom});
    wait_quiet(400);
    hang = 0;
    single_req(0, {$urandom, $urandom});
    wait_quiet(100);

    // Sticky status after set falls
    sticky = 10;
    single_req(2, {$urandom, $urandom});
    wait_quiet(100);
    sticky = 0;

    // Reset in the middle of WAIT
    lat = 8;
    single_req(1, {$urandom, $urandom});
    c = 0;
    while (set_run < 3 && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("pre_rst_set", 64'(enc_set), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rv_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    chk("no_rsp_after_rst", 64'(rv_seen), 64'd0);
    grant_log.delete();
    lat = 3; cont = 1; req_prob = 100; req_en = '1;
    wait_grants(1, 50);
    cont = 0; req_en = '0; req_prob = 0;
    if (grant_log.size() > 0) chk("rst_ptr", 64'(grant_log[0]), 64'd0);
    wait_quiet(300);

    // Randomised traffic
    lat_rand = 1; sticky_rand = 1; rdy_prob = 60; req_prob = 30; req_en = '1;
    repeat (600) @(posedge clk);
    #1;
    req_en = '0; req_prob = 0;
    wait_quiet(600);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
